// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op and state types for the multiply/divide unit
package mult_div_unit_pkg;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
    typedef enum logic [2:0] {IDLE, MUL, DIV_RUN, FIXUP, DONE} md_state_t;
endpackage

// File: rtl/mult_div_unit_div_core.sv
// mult_div_unit_div_core: one unsigned restoring-division iteration
module mult_div_unit_div_core (
    input  logic [31:0] rem,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] dividend_next,
    output logic        q_bit
);
    logic [32:0] shifted;
    logic [32:0] diff;
    always_comb begin
        shifted       = {rem, dividend[31]};
        diff          = shifted - {1'b0, divisor};
        q_bit         = shifted >= {1'b0, divisor};
        rem_next      = q_bit ? diff[31:0] : shifted[31:0];
        dividend_next = {dividend[30:0], 1'b0};
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU producing {hi, lo}
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(DIV_ITERS);
    md_state_t   state_q, state_d;
    md_op_t      op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, quot_q, quot_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        qsign_q, qsign_d, rsign_q, rsign_d, dbz_q, dbz_d;
    logic        sdiv, smul, q_bit;
    logic [31:0] core_rem, core_dvd;
    logic [63:0] prod;

    mult_div_unit_div_core u_div_core (
        .rem(rem_q), .dividend(dvd_q), .divisor(dvs_q),
        .rem_next(core_rem), .dividend_next(core_dvd), .q_bit(q_bit)
    );

    // Sign-extending to 64 bits makes the low 64 product bits the signed result.
    assign smul = op_q == MD_MULT;
    assign prod = {{32{smul & a_q[31]}}, a_q} * {{32{smul & b_q[31]}}, b_q};
    assign sdiv = op == MD_DIV;

    assign busy = (state_q == IDLE && start && !flush) ||
                  state_q == MUL || state_q == DIV_RUN || state_q == FIXUP;
    assign done = state_q == DONE;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    dvd_d   = (sdiv && a[31]) ? -a : a;
                    dvs_d   = (sdiv && b[31]) ? -b : b;
                    qsign_d = sdiv && (a[31] ^ b[31]);
                    rsign_d = sdiv && a[31];
                    dbz_d   = b == '0;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = CW'(DIV_ITERS - 1);
                    state_d = (op == MD_MULT || op == MD_MULTU) ? MUL : DIV_RUN;
                end
                MUL: begin
                    {hi_d, lo_d} = prod;
                    state_d      = DONE;
                end
                DIV_RUN: begin
                    rem_d   = core_rem;
                    dvd_d   = core_dvd;
                    quot_d  = {quot_q[30:0], q_bit};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == '0 ? FIXUP : DIV_RUN;
                end
                FIXUP: begin
                    hi_d    = dbz_q ? a_q : (rsign_q ? -rem_q : rem_q);
                    lo_d    = dbz_q ? '1 : (qsign_q ? -quot_q : quot_q);
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule
